memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 48 ++++
 rtl/memory_arbiter.sv | 125 ++++++++++++
 tb/tb_memory_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the shared memory.
// The arbiter takes the master modport; a requester/memory model takes the slave side.
interface memory_arbiter_if #(
  parameter int MEMORY_ADDRESS_SIZE = 32,
  parameter int CACHE_LINE_SIZE     = 128
);
  logic                           icache_req;
  logic [MEMORY_ADDRESS_SIZE-1:0] icache_address;
  logic [CACHE_LINE_SIZE-1:0]     icache_data_out;
  logic                           icache_ready;

  logic                           dcache_req;
  logic                           dcache_op;
  logic [MEMORY_ADDRESS_SIZE-1:0] dcache_address;
  logic [CACHE_LINE_SIZE-1:0]     dcache_data_in;
  logic [CACHE_LINE_SIZE-1:0]     dcache_data_out;
  logic                           dcache_ready;

  logic                           mem_enable;
  logic                           mem_op;
  logic [MEMORY_ADDRESS_SIZE-1:0] mem_address;
  logic [CACHE_LINE_SIZE-1:0]     mem_data_in;
  logic                           mem_in_use;
  logic [CACHE_LINE_SIZE-1:0]     mem_data_out;
  logic                           mem_data_ready;

  logic                           busy;

  modport master (
    input  icache_req, icache_address,
    output icache_data_out, icache_ready,
    input  dcache_req, dcache_op, dcache_address, dcache_data_in,
    output dcache_data_out, dcache_ready,
    output mem_enable, mem_op, mem_address, mem_data_in, mem_in_use,
    input  mem_data_out, mem_data_ready,
    output busy
  );

  modport slave (
    output icache_req, icache_address,
    input  icache_data_out, icache_ready,
    output dcache_req, dcache_op, dcache_address, dcache_data_in,
    input  dcache_data_out, dcache_ready,
    input  mem_enable, mem_op, mem_address, mem_data_in, mem_in_use,
    output mem_data_out, mem_data_ready,
    input  busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between an
// instruction cache (read-only) and a data cache (read/write).
// Every transaction is IDLE -> ISSUE_x -> RELEASE -> IDLE, so memory always
// sees mem_enable drop for at least one cycle between transactions.
module memory_arbiter #(
  parameter int MEMORY_ADDRESS_SIZE = 32,
  parameter int CACHE_LINE_SIZE     = 128
) (
  input logic clk,
  input logic reset,
  memory_arbiter_if.master bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE_I = 2'd1;
  localparam logic [1:0] ISSUE_D = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  // last_grant encoding: 0 = icache served last, 1 = dcache served last
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  logic [1:0]                     state_q, state_d;
  logic                           last_q, last_d;
  logic                           op_q, op_d;
  logic [MEMORY_ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [CACHE_LINE_SIZE-1:0]     wdata_q, wdata_d;
  logic [CACHE_LINE_SIZE-1:0]     idata_q, idata_d;
  logic [CACHE_LINE_SIZE-1:0]     ddata_q, ddata_d;
  logic                           iready_q, iready_d;
  logic                           dready_q, dready_d;
  logic                           pick_d;

  // Next-state: arbitration in IDLE, completion capture in ISSUE_x.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idata_d  = idata_q;
    ddata_d  = ddata_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    pick_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie, serve whoever was not served last.
        if (bus.icache_req && bus.dcache_req) pick_d = (last_q == GNT_I);
        else                                  pick_d = bus.dcache_req;
        if (bus.icache_req || bus.dcache_req) begin
          if (pick_d) begin
            state_d = ISSUE_D;
            op_d    = bus.dcache_op;
            addr_d  = bus.dcache_address;
            wdata_d = bus.dcache_data_in;
          end else begin
            state_d = ISSUE_I;
            op_d    = 1'b0;
            addr_d  = bus.icache_address;
            wdata_d = '0;
          end
        end
      end
      ISSUE_I: begin
        if (bus.mem_data_ready) begin
          idata_d  = bus.mem_data_out;
          iready_d = 1'b1;
          last_d   = GNT_I;
          state_d  = RELEASE;
        end
      end
      ISSUE_D: begin
        if (bus.mem_data_ready) begin
          // Writes leave the returned-line register untouched.
          if (!op_q) ddata_d = bus.mem_data_out;
          dready_d = 1'b1;
          last_d   = GNT_D;
          state_d  = RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= GNT_I;
      op_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idata_q  <= '0;
      ddata_q  <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idata_q  <= idata_d;
      ddata_q  <= ddata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
    end
  end

  // Outputs come straight from registers so they hold for the whole transaction.
  always_comb begin
    bus.mem_enable      = (state_q == ISSUE_I) || (state_q == ISSUE_D);
    bus.mem_in_use      = (state_q == ISSUE_I) || (state_q == ISSUE_D);
    bus.mem_op          = op_q;
    bus.mem_address     = addr_q;
    bus.mem_data_in     = wdata_q;
    bus.icache_data_out = idata_q;
    bus.icache_ready    = iready_q;
    bus.dcache_data_out = ddata_q;
    bus.dcache_ready    = dready_q;
    bus.busy            = (state_q != IDLE);
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small line memory responder.
module tb_memory_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam logic [LW-1:0] PAT_FF = {8{16'h00FF}};
  localparam logic [LW-1:0] PAT_DB = {4{32'hDEADBEEF}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int   mem_lat = 5;
  logic spur = 1'b0;
  int   cnt = 0;
  logic [LW-1:0] store [16];

  memory_arbiter_if #(.MEMORY_ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW)) bus ();

  memory_arbiter #(.MEMORY_ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Memory model: answers mem_lat enabled cycles after a request starts.
  always @(negedge clk) begin
    if (bus.mem_enable && !bus.mem_data_ready) begin
      cnt = cnt + 1;
      if (cnt >= mem_lat) begin
        bus.mem_data_ready = 1'b1;
        if (bus.mem_op) store[bus.mem_address[7:4]] = bus.mem_data_in;
        else            bus.mem_data_out = store[bus.mem_address[7:4]];
      end
    end else begin
      cnt = 0;
      bus.mem_data_ready = spur;
    end
  end

  task automatic wait_done(input int bound, output int cyc, output logic gi, output logic gd);
    cyc = 0; gi = 1'b0; gd = 1'b0;
    while (cyc < bound && !gi && !gd) begin
      @(negedge clk);
      cyc++;
      gi = bus.icache_ready;
      gd = bus.dcache_ready;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.mem_enable !== 1'b0 || bus.mem_in_use !== 1'b0) begin failures++; $display("FAIL reset_mem_en: en=%b use=%b want 0", bus.mem_enable, bus.mem_in_use); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.icache_ready !== 1'b0 || bus.dcache_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: i=%b d=%b want 0", bus.icache_ready, bus.dcache_ready); end
    checks++; if (bus.mem_op !== 1'b0 || bus.mem_address !== '0 || bus.mem_data_in !== '0) begin failures++; $display("FAIL reset_mem_regs: op=%b addr=%h din=%h want 0", bus.mem_op, bus.mem_address, bus.mem_data_in); end
    checks++; if (bus.icache_data_out !== '0 || bus.dcache_data_out !== '0) begin failures++; $display("FAIL reset_data_out: i=%h d=%h want 0", bus.icache_data_out, bus.dcache_data_out); end
  endtask

  task automatic test_icache_read();
    int cyc; logic gi, gd;
    mem_lat = 5;
    bus.icache_address = 32'h40;
    bus.icache_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_enable !== 1'b1 || bus.mem_in_use !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("FAIL ird_issue: en=%b use=%b busy=%b want 1", bus.mem_enable, bus.mem_in_use, bus.busy); end
    checks++; if (bus.mem_op !== 1'b0 || bus.mem_address !== 32'h40) begin failures++; $display("FAIL ird_mem_cmd: op=%b addr=%h want 0/40", bus.mem_op, bus.mem_address); end
    wait_done(50, cyc, gi, gd);
    checks++; if (gi !== 1'b1 || gd !== 1'b0) begin failures++; $display("FAIL ird_ready: i=%b d=%b want 1/0", gi, gd); end
    checks++; if (cyc != 5) begin failures++; $display("FAIL ird_latency: got %0d want 5", cyc); end
    checks++; if (bus.icache_data_out !== PAT_FF) begin failures++; $display("FAIL ird_data: got %h want %h", bus.icache_data_out, PAT_FF); end
    checks++; if (bus.mem_address !== 32'h40 || bus.mem_enable !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL ird_release: addr=%h en=%b busy=%b want 40/0/1", bus.mem_address, bus.mem_enable, bus.busy); end
    bus.icache_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.icache_ready !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL ird_pulse_end: ready=%b busy=%b want 0/0", bus.icache_ready, bus.busy); end
  endtask

  task automatic test_dcache_write_read();
    int cyc; logic gi, gd;
    mem_lat = 3;
    bus.dcache_address = 32'h0;
    bus.dcache_op = 1'b1;
    bus.dcache_data_in = PAT_DB;
    bus.dcache_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_op !== 1'b1 || bus.mem_data_in !== PAT_DB || bus.mem_address !== 32'h0) begin failures++; $display("FAIL dwr_mem_cmd: op=%b din=%h addr=%h want 1/%h/0", bus.mem_op, bus.mem_data_in, bus.mem_address, PAT_DB); end
    wait_done(50, cyc, gi, gd);
    checks++; if (gd !== 1'b1 || gi !== 1'b0 || cyc != 3) begin failures++; $display("FAIL dwr_ready: d=%b i=%b cyc=%0d want 1/0/3", gd, gi, cyc); end
    checks++; if (bus.dcache_data_out !== '0) begin failures++; $display("FAIL dwr_data_kept: got %h want 0", bus.dcache_data_out); end
    checks++; if (bus.mem_enable !== 1'b0 || bus.mem_in_use !== 1'b0) begin failures++; $display("FAIL dwr_release: en=%b use=%b want 0", bus.mem_enable, bus.mem_in_use); end
    bus.dcache_op = 1'b0;
    wait_done(50, cyc, gi, gd);
    checks++; if (gd !== 1'b1 || cyc != 5) begin failures++; $display("FAIL drd_ready: d=%b cyc=%0d want 1/5", gd, cyc); end
    checks++; if (bus.dcache_data_out !== PAT_DB) begin failures++; $display("FAIL drd_data: got %h want %h", bus.dcache_data_out, PAT_DB); end
    bus.dcache_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cyc; logic gi, gd;
    logic [2:0] want_d;
    want_d = 3'b101;  // dcache, icache, dcache
    do_reset();
    mem_lat = 2;
    bus.icache_address = 32'h40;
    bus.dcache_address = 32'h0;
    bus.dcache_op = 1'b0;
    bus.icache_req = 1'b1;
    bus.dcache_req = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_done(50, cyc, gi, gd);
      checks++; if (gd !== want_d[2-t] || gi !== !want_d[2-t]) begin failures++; $display("FAIL rr_order%0d: i=%b d=%b want d=%b", t, gi, gd, want_d[2-t]); end
      if (gd === 1'b1) begin
        checks++; if (bus.dcache_data_out !== PAT_DB) begin failures++; $display("FAIL rr_ddata%0d: got %h want %h", t, bus.dcache_data_out, PAT_DB); end
      end else begin
        checks++; if (bus.icache_data_out !== PAT_FF) begin failures++; $display("FAIL rr_idata%0d: got %h want %h", t, bus.icache_data_out, PAT_FF); end
      end
    end
    bus.icache_req = 1'b0;
    bus.dcache_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc; logic gi, gd;
    int seen;
    do_reset();
    mem_lat = 10;
    bus.icache_address = 32'h40;
    bus.icache_req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_enable !== 1'b0 || bus.busy !== 1'b0 || bus.icache_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl: en=%b busy=%b ready=%b want 0", bus.mem_enable, bus.busy, bus.icache_ready); end
    checks++; if (bus.mem_address !== '0 || bus.icache_data_out !== '0) begin failures++; $display("FAIL rst_mid_regs: addr=%h idata=%h want 0", bus.mem_address, bus.icache_data_out); end
    bus.icache_req = 1'b0;
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.icache_ready === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rst_mid_no_pulse: pulses=%0d want 0", seen); end
    mem_lat = 2;
    bus.icache_req = 1'b1;
    wait_done(50, cyc, gi, gd);
    checks++; if (gi !== 1'b1 || cyc != 3 || bus.icache_data_out !== PAT_FF) begin failures++; $display("FAIL rst_mid_fresh: i=%b cyc=%0d data=%h want 1/3/%h", gi, cyc, bus.icache_data_out, PAT_FF); end
    bus.icache_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious();
    int cyc; logic gi, gd;
    int seen;
    seen = 0;
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.icache_ready === 1'b1 || bus.dcache_ready === 1'b1 || bus.busy === 1'b1) seen++;
    end
    spur = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.icache_ready === 1'b1 || bus.dcache_ready === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL spur_ignored: events=%0d want 0", seen); end
    mem_lat = 4;
    bus.dcache_address = 32'h40;
    bus.dcache_op = 1'b0;
    bus.dcache_req = 1'b1;
    wait_done(50, cyc, gi, gd);
    checks++; if (gd !== 1'b1 || gi !== 1'b0 || cyc != 5) begin failures++; $display("FAIL spur_dread: d=%b i=%b cyc=%0d want 1/0/5", gd, gi, cyc); end
    checks++; if (bus.dcache_data_out !== PAT_FF) begin failures++; $display("FAIL spur_ddata: got %h want %h", bus.dcache_data_out, PAT_FF); end
    bus.dcache_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Both readys high together is never legal.
  int both_hi = 0;
  always @(negedge clk) if (bus.icache_ready === 1'b1 && bus.dcache_ready === 1'b1) both_hi++;

  initial begin
    for (int i = 0; i < 16; i++) store[i] = '0;
    store[4] = PAT_FF;
    bus.icache_req = 1'b0;
    bus.icache_address = '0;
    bus.dcache_req = 1'b0;
    bus.dcache_op = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_data_in = '0;
    bus.mem_data_out = '0;
    bus.mem_data_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_icache_read();
    test_dcache_write_read();
    test_round_robin();
    test_reset_mid();
    test_spurious();
    checks++; if (both_hi != 0) begin failures++; $display("FAIL both_ready: cycles=%0d want 0", both_hi); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
